fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter: DW, default 32, data width, matching the FIFO write port.
REQ-003 Parameter: MAX_BURST, default 4, maximum words per grant (1..16).
REQ-004 Reset and clock: one clock; reset is synchronous and active-high.
REQ-005 wclk  input  1  write-domain clock; all logic on its rising edge.
REQ-006 wrst  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  N_REQ  per-requester word-valid.
REQ-008 req_data  input  N_REQ*DW  per-requester data; requester i occupies bits [i*DW +: DW].
REQ-009 req_last  input  N_REQ  marks the final word of the requester's packet.
REQ-010 req_ready  output  N_REQ  per-requester accept; a word transfers when valid and ready are both high.
REQ-011 wfull  input  1  FIFO full flag.
REQ-012 winc  output  1  FIFO write strobe.
REQ-013 wdata  output  DW  FIFO write data.
REQ-014 grant_id  output  clog2(N_REQ)  index of the current grantee; holds its last value when idle.
REQ-015 busy  output  1  high while in BURST.
REQ-016 xfer_cnt  output  16  total words written; saturates at 16'hFFFF.

Function
REQ-017 FSM states: IDLE and BURST.
REQ-018 IDLE -> BURST when any req_valid is high; the grant is registered, so grant_id/busy update on the next edge.
REQ-019 Round-robin selection: search starts at index rr_ptr and wraps modulo N_REQ; the first valid index wins.
REQ-020 In BURST, req_ready[grant_id] = !wfull; all other req_ready bits are 0.
REQ-021 In IDLE, all req_ready bits are 0 and winc = 0.
REQ-022 Write path is combinational: winc = busy & req_valid[grant_id] & !wfull; wdata = req_data slice of grant_id.
REQ-023 winc never asserts while wfull = 1.
REQ-024 Burst counter beat_cnt clears on entry to BURST and increments on each winc.
REQ-025 BURST -> IDLE on any of the following:
  - a winc with req_last = 1;
  - a winc that makes beat_cnt equal MAX_BURST;
  - req_valid[grant_id] = 0 while wfull = 0 (requester stall releases the grant).
REQ-026 Holding in BURST: wfull = 1 with valid high holds BURST indefinitely and does not release the grant.
REQ-027 On every BURST -> IDLE transition, rr_ptr <= (grant_id + 1) mod N_REQ.
REQ-028 Bubble: one IDLE cycle is mandatory between bursts; no back-to-back grant.
REQ-029 Data ordering: words from one requester reach the FIFO in order; no word is duplicated or dropped.
REQ-030 xfer_cnt increments by 1 per winc and holds at 16'hFFFF.

Reset
REQ-031 While wrst is high at a wclk edge, the block SHALL load:
  - state = IDLE, rr_ptr = 0, grant_id = 0, beat_cnt = 0, xfer_cnt = 0;
  - busy = 0, winc = 0, req_ready = 0.
REQ-032 Reset mid-burst aborts the grant immediately; no winc occurs in the reset cycle or in the cycle after.
REQ-033 wdata is don't-care while winc = 0.

Verification
REQ-034 Single requester: req 2 sends 3 words A1,A2,A3 with last on A3, wfull = 0.
  - Grant one cycle after valid; winc high for 3 consecutive cycles; wdata = A1,A2,A3.
  - Then IDLE; rr_ptr = 3; xfer_cnt = 3.
REQ-035 Round-robin fairness: all 4 requesters continuously valid with 1-word packets.
  - Grant order is 0,1,2,3,0,...; each grant is separated by one IDLE cycle.
REQ-036 Burst cap: MAX_BURST = 4; req 0 streams 10 words with no last while req 1 is also valid.
  - Req 0 gets exactly 4 words, then req 1 is granted, then req 0 resumes at word 5.
REQ-037 Backpressure: wfull asserts after the 2nd word of a 4-word packet for 5 cycles.
  - winc = 0 and req_ready = 0 for those 5 cycles; grant is held.
  - Words 3,4 are written after wfull drops; no loss or duplication.
REQ-038 Stall release: the grantee drops valid after 1 word, with wfull = 0.
  - Returns to IDLE next cycle; the next valid requester in round-robin order is granted.
REQ-039 Reset mid-burst: wrst is pulsed for 1 cycle during word 2 of a 4-word packet.
  - All outputs and state take reset values; winc = 0 for 2 cycles; grant restarts from rr_ptr = 0.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin write arbiter feeding a single FIFO write port.
// Each grant is a burst from one requester. A burst ends on the packet's
// last word, after MAX_BURST words, or when the grantee stalls while the
// FIFO has room. There is always one IDLE cycle between bursts.
//
// Ports:
//   wclk       write-domain clock, rising edge
//   wrst       synchronous active-high reset
//   req_valid  per-requester word valid                  [N_REQ]
//   req_data   per-requester data, slice i at [i*DW +: DW] [N_REQ*DW]
//   req_last   per-requester end-of-packet marker          [N_REQ]
//   req_ready  per-requester accept (combinational)        [N_REQ]
//   wfull      FIFO full flag
//   winc       FIFO write strobe (combinational)
//   wdata      FIFO write data (combinational)             [DW]
//   grant_id   current or most recent grantee              [clog2(N_REQ)]
//   busy       high while a burst is granted
//   xfer_cnt   saturating count of words written           [16]
module fifo_wr_arb #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       wclk,
    input  logic                       wrst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DW-1:0]        req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       wfull,
    output logic                       winc,
    output logic [DW-1:0]              wdata,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic [15:0]                xfer_cnt
);

    localparam int unsigned GW  = $clog2(N_REQ);
    localparam int unsigned GW1 = GW + 1;
    localparam int unsigned BW  = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   rr_ptr, rr_nxt;
    logic [GW-1:0]   grant_nxt;
    logic [BW-1:0]   beat_cnt, beat_nxt;
    logic [15:0]     xfer_nxt;
    logic [GW-1:0]   rr_pick;
    logic [GW-1:0]   grant_inc;
    logic            sel_valid;
    logic            sel_last;

    // Reduce (a + b) into 0..N_REQ-1; inputs never exceed 2*N_REQ-2.
    function automatic logic [GW-1:0] wrap_idx(input logic [GW1-1:0] v);
        if (v >= GW1'(N_REQ)) begin
            return GW'(v - GW1'(N_REQ));
        end
        return GW'(v);
    endfunction

    // Round-robin pick: first valid requester at or after rr_ptr.
    always_comb begin
        logic            found;
        logic [GW-1:0]   idx;
        rr_pick = rr_ptr;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            idx = wrap_idx({1'b0, rr_ptr} + GW1'(i));
            if (!found && req_valid[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    end

    assign grant_inc = wrap_idx({1'b0, grant_id} + GW1'(1));
    assign sel_valid = req_valid[grant_id];
    assign sel_last  = req_last[grant_id];
    assign wdata     = req_data[grant_id*DW +: DW];
    assign busy      = (state == S_BURST);

    // Next-state, burst bookkeeping and the combinational write handshake.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        rr_nxt    = rr_ptr;
        beat_nxt  = beat_cnt;
        xfer_nxt  = xfer_cnt;
        winc      = 1'b0;
        req_ready = '0;

        case (state)
            S_IDLE: begin
                if (|req_valid) begin
                    state_nxt = S_BURST;
                    grant_nxt = rr_pick;
                    beat_nxt  = '0;
                end
            end
            S_BURST: begin
                req_ready[grant_id] = !wfull;
                if (!wfull) begin
                    if (sel_valid) begin
                        winc     = 1'b1;
                        beat_nxt = beat_cnt + BW'(1);
                        if (xfer_cnt != 16'hFFFF) begin
                            xfer_nxt = xfer_cnt + 16'd1;
                        end
                        if (sel_last || (beat_cnt == BW'(MAX_BURST - 1))) begin
                            state_nxt = S_IDLE;
                            rr_nxt    = grant_inc;
                        end
                    end else begin
                        // Grantee stalled with FIFO space available: release.
                        state_nxt = S_IDLE;
                        rr_nxt    = grant_inc;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Nothing may transfer in a reset cycle.
        if (wrst) begin
            winc      = 1'b0;
            req_ready = '0;
        end
    end

    // State and bookkeeping registers.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            xfer_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            grant_id <= grant_nxt;
            beat_cnt <= beat_nxt;
            xfer_cnt <= xfer_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Testbench for fifo_wr_arb: per-requester drivers with word queues, and a
// scoreboard of expected FIFO writes (data + grantee) in predicted order.
module tb_fifo_wr_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned MB = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    typedef struct {
        logic [DW-1:0] data;
        int            id;
    } exp_t;

    logic              wclk;
    logic              wrst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              wfull;
    logic              winc;
    logic [DW-1:0]     wdata;
    logic [1:0]        grant_id;
    logic              busy;
    logic [15:0]       xfer_cnt;

    word_t  drv_q [N][$];
    exp_t   exp_q [$];
    int     wcyc  [$];
    logic [N-1:0] en;
    int     cyc;
    int     n_tests;
    int     n_fail;
    bit     hold_chk;
    bit     rst_chk;

    fifo_wr_arb #(.N_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int id, input int seq);
        return {8'hA0 + 8'(id), 8'h00, 16'(seq)};
    endfunction

    task automatic add_words(input int id, input int first, input int n, input bit last_end);
        for (int k = 0; k < n; k++) begin
            word_t w;
            w.data = mk(id, first + k);
            w.last = last_end && (k == n - 1);
            drv_q[id].push_back(w);
        end
    endtask

    task automatic exp_words(input int id, input int first, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.data = mk(id, first + k);
            e.id   = id;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < int'(N); i++) begin
            if (en[i] && drv_q[i].size() > 0) begin
                req_valid[i]           = 1'b1;
                req_data[i*DW +: DW]   = drv_q[i][0].data;
                req_last[i]            = drv_q[i][0].last;
            end else begin
                req_valid[i]           = 1'b0;
                req_data[i*DW +: DW]   = '0;
                req_last[i]            = 1'b0;
            end
        end
    endtask

    // One clock: sample/score at negedge, advance drivers just after posedge.
    task automatic step();
        logic [N-1:0] fire;
        exp_t e;
        @(negedge wclk);
        check("winc_while_full", {31'b0, winc & wfull}, 32'd0);
        if (hold_chk) begin
            check("bp_winc",  {31'b0, winc}, 32'd0);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_busy",  {31'b0, busy}, 32'd1);
            check("bp_grant", 32'(grant_id), 32'd1);
        end
        if (rst_chk) begin
            check("rst_winc",  {31'b0, winc}, 32'd0);
            check("rst_ready", 32'(req_ready), 32'd0);
        end
        if (winc) begin
            wcyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("winc_unexpected", {31'b0, winc}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wdata", wdata, e.data);
                check("grant_id", 32'(grant_id), 32'(e.id));
            end
        end
        fire = req_valid & req_ready;
        @(posedge wclk);
        #1;
        for (int i = 0; i < int'(N); i++) begin
            if (fire[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        end
        cyc++;
        drive();
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!(exp_q.size() == 0 && !busy) && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) check("timeout_idle", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_wincs(input int n, input int budget);
        int k;
        k = 0;
        while (wcyc.size() < n && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) check("timeout_winc", 32'(wcyc.size()), 32'(n));
    endtask

    task automatic do_reset();
        for (int i = 0; i < int'(N); i++) drv_q[i].delete();
        exp_q.delete();
        drive();
        wrst = 1'b1;
        step();
        step();
        check("reset_busy",  {31'b0, busy}, 32'd0);
        check("reset_winc",  {31'b0, winc}, 32'd0);
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_grant", 32'(grant_id), 32'd0);
        check("reset_xfer",  32'(xfer_cnt), 32'd0);
        wrst = 1'b0;
    endtask

    initial begin
        int c0;
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        hold_chk  = 1'b0;
        rst_chk   = 1'b0;
        en        = '1;
        wfull     = 1'b0;
        wrst      = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;

        // Reset state.
        do_reset();

        // Single requester: req 2 sends A1..A3, last on A3.
        wcyc.delete();
        add_words(2, 1, 3, 1'b1);
        exp_words(2, 1, 3);
        c0 = cyc;
        drive();
        wait_idle(50);
        wait_wincs(3, 20);
        if (wcyc.size() >= 3) begin
            check("s1_first_winc", 32'(wcyc[0]), 32'(c0 + 1));
            check("s1_consec",     32'(wcyc[2] - wcyc[0]), 32'd2);
        end
        check("s1_xfer", 32'(xfer_cnt), 32'd3);
        check("s1_busy", {31'b0, busy}, 32'd0);

        // rr_ptr is now 3: with req 1 and req 3 both valid, req 3 goes first.
        add_words(1, 1, 1, 1'b1);
        add_words(3, 1, 1, 1'b1);
        exp_words(3, 1, 1);
        exp_words(1, 1, 1);
        drive();
        wait_idle(50);
        check("s1b_xfer", 32'(xfer_cnt), 32'd5);

        // Fairness: all valid with 1-word packets, grants 0,1,2,3,0,1,2,3.
        do_reset();
        wcyc.delete();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < int'(N); i++) begin
                add_words(i, r + 1, 1, 1'b1);
                exp_words(i, r + 1, 1);
            end
        end
        drive();
        wait_idle(100);
        wait_wincs(8, 20);
        for (int k = 0; k + 1 < wcyc.size(); k++) begin
            check("s2_spacing", 32'(wcyc[k+1] - wcyc[k]), 32'd2);
        end
        check("s2_xfer", 32'(xfer_cnt), 32'd8);

        // Burst cap: req 0 streams 10 words without last, req 1 has 3 words.
        add_words(0, 1, 10, 1'b0);
        add_words(1, 1, 3, 1'b1);
        exp_words(0, 1, 4);
        exp_words(1, 1, 3);
        exp_words(0, 5, 4);
        exp_words(0, 9, 2);
        drive();
        wait_idle(200);
        check("s3_xfer", 32'(xfer_cnt), 32'd21);

        // Backpressure: wfull for 5 cycles after word 2 of a 4-word packet.
        wcyc.delete();
        add_words(1, 1, 4, 1'b1);
        exp_words(1, 1, 4);
        drive();
        wait_wincs(2, 20);
        wfull    = 1'b1;
        hold_chk = 1'b1;
        repeat (5) step();
        hold_chk = 1'b0;
        wfull    = 1'b0;
        wait_idle(50);
        wait_wincs(4, 20);
        if (wcyc.size() >= 4) begin
            check("s4_gap", 32'(wcyc[2] - wcyc[1]), 32'd6);
        end
        check("s4_xfer", 32'(xfer_cnt), 32'd25);

        // Stall release: req 2 drops valid after 1 word, req 3 is next.
        wcyc.delete();
        add_words(2, 1, 3, 1'b1);
        add_words(3, 1, 1, 1'b1);
        exp_words(2, 1, 1);
        exp_words(3, 1, 1);
        exp_words(2, 2, 2);
        drive();
        wait_wincs(1, 20);
        en[2] = 1'b0;
        drive();
        wait_wincs(2, 20);
        if (wcyc.size() >= 2) begin
            check("s5_release_gap", 32'(wcyc[1] - wcyc[0]), 32'd3);
        end
        en[2] = 1'b1;
        drive();
        wait_idle(50);
        check("s5_xfer", 32'(xfer_cnt), 32'd29);

        // Reset during word 2 of req 1's packet; grant restarts from rr_ptr 0.
        wcyc.delete();
        add_words(1, 1, 4, 1'b1);
        exp_words(1, 1, 4);
        exp_words(3, 1, 1);
        drive();
        wait_wincs(1, 20);
        wrst    = 1'b1;
        rst_chk = 1'b1;
        add_words(3, 1, 1, 1'b1);
        drive();
        step();
        wrst = 1'b0;
        check("s6_busy",  {31'b0, busy}, 32'd0);
        check("s6_grant", 32'(grant_id), 32'd0);
        check("s6_xfer",  32'(xfer_cnt), 32'd0);
        step();
        rst_chk = 1'b0;
        wait_idle(50);
        check("s6_xfer_after", 32'(xfer_cnt), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
